vedic_mul16_seq: RTL and testbench
==================================

VEDIC_MUL16_SEQ -- requirements
Module: vedic_mul16_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 and the internal multiplier width at 8.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST_n  input  1  reset; asynchronous, active-low.
REQ-004 IN_VALID  input  1  requester presents an operand pair.
REQ-005 IN_READY  output  1  block accepts an operand pair this cycle.
REQ-006 A  input  16  unsigned multiplicand, sampled on accept.
REQ-007 B  input  16  unsigned multiplier, sampled on accept.
REQ-008 OUT_VALID  output  1  P holds a completed product.
REQ-009 OUT_READY  input  1  consumer takes the product.
REQ-010 P  output  32  unsigned product A*B.
REQ-011 BUSY  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL compute the 16x16 product by time-sharing exactly one vedic_8bits instance (8x8 -> 16-bit) across partial-product steps.
REQ-013 FSM states SHALL be IDLE, MUL and DONE, with a 2-bit step counter that is used only in MUL.
REQ-014 IN_READY SHALL equal (state==IDLE), driven combinationally from the state register.
REQ-015 Accept SHALL occur when IN_VALID&&IN_READY at a rising edge: A and B are registered, the 32-bit accumulator is cleared, step=0, and the state goes to MUL.
REQ-016 MUL steps SHALL be: step0 A[7:0]*B[7:0]<<0; step1 A[15:8]*B[7:0]<<8; step2 A[7:0]*B[15:8]<<8; step3 A[15:8]*B[15:8]<<16.
REQ-017 Each step SHALL add its shifted partial product to the accumulator in one cycle, with 32-bit width; no overflow is possible.
REQ-018 After step3 the state SHALL go to DONE, with P=accumulator and OUT_VALID=1.
REQ-019 Latency SHALL be fixed: with accept at edge k, OUT_VALID rises after edge k+4.
REQ-020 In DONE, OUT_VALID and P SHALL hold stable until OUT_VALID&&OUT_READY at an edge, after which the state goes to IDLE and OUT_VALID goes to 0.
REQ-021 P SHALL retain the last product after hand-off until the next result is written.
REQ-022 IN_VALID SHALL be ignored in MUL and DONE, and A/B changes in those states SHALL have no effect on the result.
REQ-023 The minimum issue interval SHALL be 6 cycles: accept, 4 MUL cycles, and at least 1 DONE cycle, followed by an IDLE cycle.
REQ-024 OUT_READY held high before DONE is entered SHALL complete the hand-off in the first DONE cycle.

Reset
REQ-025 RST_n low SHALL immediately force state=IDLE, step=0, accumulator=0, P=0, OUT_VALID=0 and BUSY=0, with IN_READY=1.
REQ-026 Reset asserted in MUL or DONE SHALL discard the in-flight operation with no OUT_VALID pulse.
REQ-027 After RST_n deasserts, the first accept SHALL be possible at the next rising edge.

Configuration
REQ-028 Macro VEDIC_ZERO_SKIP_EN: when defined, an accept with A==0 or B==0 SHALL go directly to DONE with P=0, so OUT_VALID rises after edge k+1.
REQ-029 Without VEDIC_ZERO_SKIP_EN, zero operands SHALL take the full 4-step path, with latency identical to REQ-019.

Verification
REQ-030 Apply A=0x1234, B=0x5678 with OUT_READY=1; required: P=0x06260060 and OUT_VALID high exactly 4 cycles after accept, for 1 cycle.
REQ-031 Apply A=0xFFFF, B=0xFFFF; required: P=0xFFFE0001.
REQ-032 Apply A=0x00FF, B=0x0100 with OUT_READY=0 for 3 DONE cycles, then 1; required: P=0x0000FF00 stable and OUT_VALID high for 4 cycles, then IDLE.
REQ-033 Pulse IN_VALID with A=0x0002, B=0x0003 during MUL of A=0x0010, B=0x0010; required: P=0x00000100, the second pair is not accepted, and IN_READY=0.
REQ-034 Assert RST_n=0 at MUL step2 of 0xABCD*0x1111; required: OUT_VALID=0, P=0 and IN_READY=1 immediately, and no product emitted.
REQ-035 Apply A=0x0000, B=0xABCD; required: P=0, with OUT_VALID after 1 cycle when VEDIC_ZERO_SKIP_EN is defined, else after 4.

Source files
------------

// File: rtl/vedic_mul16_seq.sv
// -----------------------------------------------------------------------------
// vedic_mul16_seq -- sequential 16x16 unsigned multiplier.
//
// One 8x8 Vedic (Urdhva-Tiryagbhyam) multiplier is time-shared over four
// partial-product steps. The 32-bit accumulator gathers the shifted partial
// products, and the finished product is presented with a valid/ready hand-off.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   RST_n      in   1   asynchronous active-low reset
//   IN_VALID   in   1   operand pair offered
//   IN_READY   out  1   operand pair accepted this cycle (state is IDLE)
//   A, B       in  16   unsigned operands, sampled on accept
//   OUT_VALID  out  1   P holds a completed product
//   OUT_READY  in   1   consumer takes the product
//   P          out 32   product A*B; keeps the last result after hand-off
//   BUSY       out  1   state is not IDLE
//
// Build option:
//   VEDIC_ZERO_SKIP_EN -- when defined, a zero operand ends the operation
//   after the first MUL cycle with P=0, so the result is ready one cycle
//   after accept. When undefined, every operation takes all four steps.
// -----------------------------------------------------------------------------

// 2x2 Vedic cell: vertical and crosswise products with a single carry.
module vedic_2bits (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic cross_a_s;
  logic cross_b_s;
  logic carry_s;
  logic high_s;

  assign cross_a_s = a_i[1] & b_i[0];
  assign cross_b_s = a_i[0] & b_i[1];
  assign carry_s   = cross_a_s & cross_b_s;
  assign high_s    = a_i[1] & b_i[1];

  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = cross_a_s ^ cross_b_s;
  assign p_o[2] = high_s ^ carry_s;
  assign p_o[3] = high_s & carry_s;
endmodule

// 4x4 Vedic multiplier assembled from four 2x2 cells.
module vedic_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0] q0_s;
  logic [3:0] q1_s;
  logic [3:0] q2_s;
  logic [3:0] q3_s;

  vedic_2bits u_q0 (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(q0_s));
  vedic_2bits u_q1 (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(q1_s));
  vedic_2bits u_q2 (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(q2_s));
  vedic_2bits u_q3 (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(q3_s));

  assign p_o = {4'b0000, q0_s}
             + {2'b00, q1_s, 2'b00}
             + {2'b00, q2_s, 2'b00}
             + {q3_s, 4'b0000};
endmodule

// 8x8 Vedic multiplier assembled from four 4x4 blocks.
module vedic_8bits (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  logic [7:0] q0_s;
  logic [7:0] q1_s;
  logic [7:0] q2_s;
  logic [7:0] q3_s;

  vedic_4bits u_q0 (.a_i(a_i[3:0]), .b_i(b_i[3:0]), .p_o(q0_s));
  vedic_4bits u_q1 (.a_i(a_i[7:4]), .b_i(b_i[3:0]), .p_o(q1_s));
  vedic_4bits u_q2 (.a_i(a_i[3:0]), .b_i(b_i[7:4]), .p_o(q2_s));
  vedic_4bits u_q3 (.a_i(a_i[7:4]), .b_i(b_i[7:4]), .p_o(q3_s));

  assign p_o = {8'h00, q0_s}
             + {4'h0, q1_s, 4'h0}
             + {4'h0, q2_s, 4'h0}
             + {q3_s, 8'h00};
endmodule

module vedic_mul16_seq (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] P,
  output logic        BUSY
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] p_q, p_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  op_a_s;
  logic [7:0]  op_b_s;
  logic [15:0] pp_s;
  logic [31:0] pp_shift_s;
  logic [31:0] acc_sum_s;

  // Step bit 0 picks the high byte of A, step bit 1 the high byte of B:
  // step0 lo*lo, step1 hi*lo, step2 lo*hi, step3 hi*hi.
  assign op_a_s = step_q[0] ? a_q[15:8] : a_q[7:0];
  assign op_b_s = step_q[1] ? b_q[15:8] : b_q[7:0];

  vedic_8bits u_vedic (
    .a_i (op_a_s),
    .b_i (op_b_s),
    .p_o (pp_s)
  );

  // Align the partial product by the byte weight of the current step.
  always_comb begin
    pp_shift_s = 32'h0000_0000;
    case (step_q)
      2'd0:    pp_shift_s = {16'h0000, pp_s};
      2'd1:    pp_shift_s = {8'h00, pp_s, 8'h00};
      2'd2:    pp_shift_s = {8'h00, pp_s, 8'h00};
      2'd3:    pp_shift_s = {pp_s, 16'h0000};
      default: pp_shift_s = 32'h0000_0000;
    endcase
  end

  assign acc_sum_s = acc_q + pp_shift_s;

  // Next-state and datapath control for the IDLE -> MUL -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        step_d = 2'd0;
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          acc_d   = 32'h0000_0000;
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
`ifdef VEDIC_ZERO_SKIP_EN
        // A zero operand makes the product zero; finish on the first step.
        if ((step_q == 2'd0) && ((a_q == 16'h0000) || (b_q == 16'h0000))) begin
          p_d         = 32'h0000_0000;
          acc_d       = 32'h0000_0000;
          out_valid_d = 1'b1;
          step_d      = 2'd0;
          state_d     = ST_DONE;
        end else
`endif
        begin
          acc_d = acc_sum_s;
          if (step_q == 2'd3) begin
            p_d         = acc_sum_s;
            out_valid_d = 1'b1;
            step_d      = 2'd0;
            state_d     = ST_DONE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = ST_MUL;
          end
        end
      end
      ST_DONE: begin
        step_d = 2'd0;
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        step_d      = 2'd0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, operand, accumulator and result registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      acc_q       <= 32'h0000_0000;
      p_q         <= 32'h0000_0000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign OUT_VALID = out_valid_q;
  assign P         = p_q;
endmodule

// File: tb/tb_vedic_mul16_seq.sv
// -----------------------------------------------------------------------------
// tb_vedic_mul16_seq -- self-checking bench for vedic_mul16_seq.
// Expected products come from plain 32-bit arithmetic; expected latency is
// 4 cycles, or 1 cycle for a zero operand when VEDIC_ZERO_SKIP_EN is defined.
// -----------------------------------------------------------------------------
module tb_vedic_mul16_seq;
  logic        CLK;
  logic        RST_n;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] A;
  logic [15:0] B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] P;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vedic_mul16_seq dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .P         (P),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  function automatic int exp_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef VEDIC_ZERO_SKIP_EN
    if (a == 16'h0000 || b == 16'h0000) return 1;
`endif
    return 4;
  endfunction

  // Drives one operation (inputs change 1 time unit after the edge) and
  // reports what it observed. OUT_READY is held high from the start when
  // hold==0, otherwise it is released after 'hold' DONE cycles.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                        input bit poke, output logic [31:0] prod, output int lat,
                        output int vcnt, output bit unstable, output bit busy_seen,
                        output bit rdy_seen, output int acc_cyc);
    OUT_READY = (hold == 0);
    A = a; B = b; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    acc_cyc = cyc;
    IN_VALID = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    busy_seen = BUSY;
    rdy_seen  = IN_READY;
    lat = 0; vcnt = 0; unstable = 1'b0;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      if (poke && lat == 1) begin
        IN_VALID = 1'b1; A = 16'h0002; B = 16'h0003;
        if (IN_READY !== 1'b0) rdy_seen = 1'b1;
      end else begin
        IN_VALID = 1'b0;
      end
      @(posedge CLK); #1;
      lat++;
      A = 16'($urandom); B = 16'($urandom);
    end
    IN_VALID = 1'b0;
    prod = P;
    while (OUT_VALID === 1'b1 && vcnt < 50) begin
      vcnt++;
      if (P !== prod) unstable = 1'b1;
      OUT_READY = (vcnt > hold);
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; A = 16'h0; B = 16'h0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", OUT_VALID); end
    checks++; if (P !== 32'h0) begin failures++; $display("FAIL reset_p got=%h exp=00000000", P); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    RST_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] prod; int lat, vcnt, ac; bit uns, bsy, rdy;
    run_op(16'h1234, 16'h5678, 0, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (prod !== 32'h06260060) begin failures++; $display("FAIL dir_1234x5678 got=%h exp=06260060", prod); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL dir_latency got=%0d exp=4", lat); end
    checks++; if (vcnt !== 1) begin failures++; $display("FAIL dir_valid_cycles got=%0d exp=1", vcnt); end
    checks++; if (bsy !== 1'b1) begin failures++; $display("FAIL dir_busy_in_mul got=%b exp=1", bsy); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL dir_ready_in_mul got=%b exp=0", rdy); end
    checks++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL dir_idle_after got=%b%b exp=10", IN_READY, BUSY); end
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (prod !== 32'hFFFE0001) begin failures++; $display("FAIL dir_ffffxffff got=%h exp=FFFE0001", prod); end
  endtask

  task automatic test_backpressure();
    logic [31:0] prod; int lat, vcnt, ac; bit uns, bsy, rdy;
    run_op(16'h00FF, 16'h0100, 3, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (prod !== 32'h0000FF00) begin failures++; $display("FAIL bp_product got=%h exp=0000FF00", prod); end
    checks++; if (vcnt !== 4) begin failures++; $display("FAIL bp_valid_cycles got=%0d exp=4", vcnt); end
    checks++; if (uns !== 1'b0) begin failures++; $display("FAIL bp_p_stable got=%b exp=0", uns); end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL bp_idle_after got=%b exp=1", IN_READY); end
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (P !== 32'h0000FF00) begin failures++; $display("FAIL bp_p_retained got=%h exp=0000FF00", P); end
  endtask

  task automatic test_ignore_in_valid();
    logic [31:0] prod; int lat, vcnt, ac, extra; bit uns, bsy, rdy;
    run_op(16'h0010, 16'h0010, 0, 1'b1, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (prod !== 32'h00000100) begin failures++; $display("FAIL ign_product got=%h exp=00000100", prod); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ign_in_ready got=%b exp=0", rdy); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    extra = 0;
    OUT_READY = 1'b1;
    repeat (8) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1 || BUSY === 1'b1) extra++;
    end
    OUT_READY = 1'b0;
    checks++; if (extra !== 0) begin failures++; $display("FAIL ign_second_pair got=%0d active cycles exp=0", extra); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] prod; int lat, vcnt, ac, pulses; bit uns, bsy, rdy;
    A = 16'hABCD; B = 16'h1111; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(posedge CLK); #1;        // accepted; step0 this cycle
    IN_VALID = 1'b0;
    @(posedge CLK); #1;        // step1
    @(posedge CLK); #1;        // step2
    RST_n = 1'b0;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", OUT_VALID); end
    checks++; if (P !== 32'h0) begin failures++; $display("FAIL rst_mid_p got=%h exp=00000000", P); end
    checks++; if (IN_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b%b exp=10", IN_READY, BUSY); end
    #2 RST_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (OUT_VALID === 1'b1) pulses++;
    end
    OUT_READY = 1'b0;
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_mid_no_product got=%0d exp=0", pulses); end
    // First accept right after reset release.
    RST_n = 1'b0; #2 RST_n = 1'b1;
    run_op(16'h0003, 16'h0005, 0, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (bsy !== 1'b1 || prod !== 32'h0000000F) begin failures++; $display("FAIL rst_first_accept got=%b/%h exp=1/0000000F", bsy, prod); end
  endtask

  task automatic test_zero();
    logic [31:0] prod; int lat, vcnt, ac, el; bit uns, bsy, rdy;
    el = exp_latency(16'h0000, 16'hABCD);
    run_op(16'h0000, 16'hABCD, 0, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
    checks++; if (prod !== 32'h0) begin failures++; $display("FAIL zero_product got=%h exp=00000000", prod); end
    checks++; if (lat !== el) begin failures++; $display("FAIL zero_latency got=%0d exp=%0d", lat, el); end
  endtask

  task automatic test_random();
    logic [31:0] prod, expv; logic [15:0] a, b; int lat, vcnt, ac, hold, el; bit uns, bsy, rdy;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h0000;
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      hold = $urandom_range(0, 2);
      expv = 32'(a) * 32'(b);
      el = exp_latency(a, b);
      run_op(a, b, hold, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
      checks++; if (prod !== expv) begin failures++; $display("FAIL rnd_product %h*%h got=%h exp=%h", a, b, prod, expv); end
      checks++; if (lat !== el) begin failures++; $display("FAIL rnd_latency %h*%h got=%0d exp=%0d", a, b, lat, el); end
      checks++; if (vcnt !== hold + 1 || uns !== 1'b0) begin failures++; $display("FAIL rnd_handoff got=%0d/%b exp=%0d/0", vcnt, uns, hold + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prod; logic [15:0] a, b; int lat, vcnt, ac, prev_ac; bit uns, bsy, rdy;
    prev_ac = -1;
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(1, 65535)); b = 16'($urandom_range(1, 65535));
      run_op(a, b, 0, 1'b0, prod, lat, vcnt, uns, bsy, rdy, ac);
      checks++; if (prod !== 32'(a) * 32'(b)) begin failures++; $display("FAIL b2b_product got=%h exp=%h", prod, 32'(a) * 32'(b)); end
      if (prev_ac >= 0) begin
        checks++; if (ac - prev_ac !== 6) begin failures++; $display("FAIL b2b_interval got=%0d exp=6", ac - prev_ac); end
      end
      checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", IN_READY); end
      prev_ac = ac;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_midflight();
    test_zero();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
